vape_exec_monitor: RTL and testbench

VAPE_EXEC_MONITOR -- requirements
Module: vape_exec_monitor

---
 rtl/vape_exec_monitor.sv | 106 ++++++++++
 tb/tb_vape_exec_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vape_exec_monitor.sv
//------------------------------------------------------------------------------
// Module  : vape_exec_monitor
// Brief   : Watches PC, IRQ and DMA activity to flag a legal, untampered run
//           through the executable region [ER_min, ER_max].
//           Optional completion counter enabled by macro VAPE_DONE_CNT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vape_exec_monitor (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  input  logic        irq,
  input  logic        dma_en,
  input  logic        exec_imm,
  input  logic [15:0] ER_min,
  input  logic [15:0] ER_max,
  output logic        exec,
  output logic        er_active,
  output logic [7:0]  done_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_pc_prev;
  logic        r_exec;
  logic        r_er_active;

  logic w_in_er;
  logic w_at_entry;
  logic w_entry_ok;
  logic w_run_abort;

  assign w_in_er     = (pc >= ER_min) && (pc <= ER_max);
  assign w_at_entry  = (pc == ER_min);
  assign w_entry_ok  = w_at_entry && !irq && !dma_en;
  // Leaving the ER anywhere other than from its last address is a violation
  assign w_run_abort = irq || dma_en || !exec_imm ||
                       (!w_in_er && (r_pc_prev != ER_max));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, ABORT: begin
        if (w_entry_ok) w_next = RUN;
      end
      RUN: begin
        if (w_run_abort)  w_next = ABORT;
        else if (!w_in_er) w_next = DONE;
        else               w_next = RUN;
      end
      DONE: begin
        if (w_entry_ok)                    w_next = RUN;
        else if (!exec_imm && !w_at_entry) w_next = ABORT;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pc_prev   <= 16'h0000;
      r_exec      <= 1'b0;
      r_er_active <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_pc_prev   <= pc;
      r_exec      <= (w_next == DONE);
      r_er_active <= (w_next == RUN);
    end
  end

  assign exec      = r_exec;
  assign er_active = r_er_active;

`ifdef VAPE_DONE_CNT_EN
  logic [7:0] r_done_cnt;
  logic       w_complete;

  assign w_complete = (r_state == RUN) && (w_next == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done_cnt <= 8'h00;
    end else if (w_complete && (r_done_cnt != 8'hFF)) begin
      r_done_cnt <= r_done_cnt + 8'h01;
    end
  end

  assign done_cnt = r_done_cnt;
`else
  assign done_cnt = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vape_exec_monitor.sv
//------------------------------------------------------------------------------
// Module  : tb_vape_exec_monitor
// Brief   : Directed self-checking bench for vape_exec_monitor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vape_exec_monitor;

`ifdef VAPE_DONE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [15:0] pc;
  logic        irq;
  logic        dma_en;
  logic        exec_imm;
  logic [15:0] ER_min;
  logic [15:0] ER_max;
  logic        exec;
  logic        er_active;
  logic [7:0]  done_cnt;

  int checks;
  int errors;
  logic [7:0] exp_cnt;

  vape_exec_monitor dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pc        (pc),
    .irq       (irq),
    .dma_en    (dma_en),
    .exec_imm  (exec_imm),
    .ER_min    (ER_min),
    .ER_max    (ER_max),
    .exec      (exec),
    .er_active (er_active),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_cnt();
    if (CNT_EN && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stimulus helper: full legal run ending in DONE
  task automatic run_legal(input logic [15:0] lo, input logic [15:0] hi);
    pc = lo; exec_imm = 1'b1; irq = 1'b0; dma_en = 1'b0;
    tick();
    for (int a = int'(lo) + 1; a <= int'(hi); a++) begin
      pc = 16'(a);
      tick();
    end
    pc = 16'hF000;
    tick();
    bump_cnt();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pc = 16'h0000; irq = 1'b0; dma_en = 1'b0; exec_imm = 1'b0;
    ER_min = 16'hE000; ER_max = 16'hE0FE; exp_cnt = 8'h00;
    #3;
    chk("reset_exec", {15'd0, exec}, 16'd0);
    chk("reset_er_active", {15'd0, er_active}, 16'd0);
    chk("reset_done_cnt", {8'd0, done_cnt}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("post_reset_idle", {15'd0, er_active}, 16'd0);
  endtask

  task automatic test_legal_run();
    int bad;
    bad = 0;
    pc = 16'hE000; exec_imm = 1'b0;
    tick();
    chk("legal_entry_active", {15'd0, er_active}, 16'd1);
    exec_imm = 1'b1;
    for (int a = 16'hE001; a <= 16'hE0FE; a++) begin
      pc = 16'(a);
      tick();
      if (er_active !== 1'b1 || exec !== 1'b0) bad++;
    end
    chk("legal_run_body", 16'(bad), 16'd0);
    pc = 16'hF000;
    tick();
    bump_cnt();
    chk("legal_exec", {15'd0, exec}, 16'd1);
    chk("legal_er_inactive", {15'd0, er_active}, 16'd0);
    chk("legal_done_cnt", {8'd0, done_cnt}, {8'd0, exp_cnt});
    tick();
    chk("legal_exec_hold", {15'd0, exec}, 16'd1);
  endtask

  task automatic test_early_exit();
    pc = 16'hE000;
    tick();
    chk("reentry_exec_clear", {15'd0, exec}, 16'd0);
    chk("reentry_active", {15'd0, er_active}, 16'd1);
    pc = 16'hE010;
    tick();
    pc = 16'hF000;
    tick();
    chk("early_exec", {15'd0, exec}, 16'd0);
    chk("early_er_active", {15'd0, er_active}, 16'd0);
    chk("early_done_cnt", {8'd0, done_cnt}, {8'd0, exp_cnt});
  endtask

  task automatic test_irq();
    pc = 16'hE000;
    tick();
    pc = 16'hE020; irq = 1'b1;
    tick();
    chk("irq_abort_active", {15'd0, er_active}, 16'd0);
    chk("irq_abort_exec", {15'd0, exec}, 16'd0);
    pc = 16'hE000; irq = 1'b0;
    tick();
    chk("irq_reentry", {15'd0, er_active}, 16'd1);
    pc = 16'hF000;
    tick();
    pc = 16'hE000; irq = 1'b1;
    tick();
    chk("irq_entry_refused", {15'd0, er_active}, 16'd0);
    irq = 1'b0; dma_en = 1'b1;
    tick();
    chk("dma_entry_refused", {15'd0, er_active}, 16'd0);
    dma_en = 1'b0;
    tick();
    pc = 16'hE030; dma_en = 1'b1;
    tick();
    chk("dma_abort", {15'd0, er_active}, 16'd0);
    dma_en = 1'b0;
  endtask

  task automatic test_tamper();
    run_legal(16'hE000, 16'hE0FE);
    chk("tamper_pre_exec", {15'd0, exec}, 16'd1);
    pc = 16'hF100; exec_imm = 1'b0;
    tick();
    chk("tamper_exec_fall", {15'd0, exec}, 16'd0);
    exec_imm = 1'b1;
    tick();
    chk("tamper_abort_state", {15'd0, exec}, 16'd0);
    chk("tamper_done_cnt", {8'd0, done_cnt}, {8'd0, exp_cnt});
  endtask

  task automatic test_inverted_er();
    ER_min = 16'hE100; ER_max = 16'hE0FF;
    pc = 16'hE100;
    tick();
    chk("inv_entry", {15'd0, er_active}, 16'd1);
    pc = 16'hE101;
    tick();
    chk("inv_abort", {15'd0, er_active}, 16'd0);
    chk("inv_no_exec", {15'd0, exec}, 16'd0);
    ER_min = 16'hE000; ER_max = 16'hE0FE;
    pc = 16'hF000;
    tick();
  endtask

  task automatic test_reset_midrun();
    run_legal(16'hE000, 16'hE0FE);
    pc = 16'hE000;
    tick();
    pc = 16'hE040;
    tick();
    chk("midrun_active", {15'd0, er_active}, 16'd1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    exp_cnt = 8'h00;
    chk("midrun_rst_exec", {15'd0, exec}, 16'd0);
    chk("midrun_rst_active", {15'd0, er_active}, 16'd0);
    chk("midrun_rst_cnt", {8'd0, done_cnt}, 16'd0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("midrun_after_rst", {15'd0, er_active}, 16'd0);
  endtask

  task automatic test_saturation();
`ifdef VAPE_DONE_CNT_EN
    ER_min = 16'hE000; ER_max = 16'hE003;
    for (int r = 0; r < 255; r++) run_legal(16'hE000, 16'hE003);
    chk("sat_255", {8'd0, done_cnt}, 16'h00FF);
    run_legal(16'hE000, 16'hE003);
    chk("sat_256", {8'd0, done_cnt}, 16'h00FF);
    ER_min = 16'hE000; ER_max = 16'hE0FE;
`else
    run_legal(16'hE000, 16'hE0FE);
    chk("cnt_disabled", {8'd0, done_cnt}, 16'd0);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_legal_run();
    test_early_exit();
    test_irq();
    test_tamper();
    test_inverted_er();
    test_reset_midrun();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
